// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and sizing constants for the four-requester
//               round-robin arbiter and its interface.
//               Contents: arb_state_e (ARB_IDLE / ARB_GRANT), NUM_REQ, IDX_W.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter_4_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4_if
// Description : Request/grant bundle between the requesting masters and the
//               round-robin arbiter.
//   req       : request vector, bit k = master k       (master -> arbiter)
//   done      : release pulse from the current owner   (master -> arbiter)
//   gnt       : registered one-hot grant               (arbiter -> master)
//   gnt_idx   : binary index of the granted master     (arbiter -> master)
//   gnt_valid : high whenever gnt is non-zero          (arbiter -> master)
//   timeout   : pulse when a grant hit the hold limit  (arbiter -> master)
//   Modports  : master (requester side), slave (arbiter side)
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface : rr_arbiter_4_if
`default_nettype wire

// File: rtl/onehot_to_idx4.sv
`default_nettype none
// ============================================================================
// Module      : onehot_to_idx4
// Description : Combinational 4-bit one-hot to 2-bit index/valid encoder.
//               All-zero input yields idx = 2'b00 with valid = 0.
//   onehot : one-hot (or all-zero) input vector
//   idx    : binary index of the set bit
//   valid  : high when any input bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_idx4
  import arb_pkg::*;
(
  input  wire  [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // OR-tree encoding: assumes at most one bit set, which the arbiter guarantees.
  assign idx[1] = onehot[3] | onehot[2];
  assign idx[0] = onehot[3] | onehot[1];
  assign valid  = |onehot;

endmodule : onehot_to_idx4
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter. Issues a registered
//               one-hot grant that is held until the owner pulses done,
//               drops its request, or MAX_HOLD cycles elapse. Each release
//               is followed by one idle bubble; priority rotates to the
//               master just above the previous owner.
//   MAX_HOLD : maximum cycles a grant may be held (2..256)
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : rr_arbiter_4_if.slave (req, done in; gnt, gnt_idx,
//              gnt_valid, timeout out)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input wire            clk,
  input wire            rst_n,
  rr_arbiter_4_if.slave bus
);

  localparam int                 CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     rot_first;
  logic [IDX_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]   win_onehot;
  logic                 hold_limit;
  logic                 owner_req;
  logic                 release_now;

  // Index is always derived from the registered grant so the three grant
  // outputs can never disagree.
  onehot_to_idx4 u_enc (
    .onehot (gnt_q),
    .idx    (gnt_idx),
    .valid  (gnt_valid)
  );

  // Rotate right by ptr: bit i of req_rot is req[(ptr + i) mod 4], so the
  // lowest set bit of req_rot is the first requester at or above ptr.
  assign req_dbl = {bus.req, bus.req};
  assign req_rot = req_dbl[ptr_q +: NUM_REQ];

  always_comb begin
    rot_first = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rot_first = IDX_W'(i);
      end
    end
  end

  // Rotate back: the 2-bit add wraps naturally modulo 4.
  assign win_idx    = rot_first + ptr_q;
  assign win_onehot = NUM_REQ'(1) << win_idx;

  assign hold_limit  = (hold_q == HOLD_LAST);
  assign owner_req   = bus.req[gnt_idx];
  assign release_now = bus.done || !owner_req || hold_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|bus.req) begin
          state_d = ARB_GRANT;
          gnt_d   = win_onehot;
          hold_d  = '0;
        end
      end
      ARB_GRANT: begin
        if (release_now) begin
          state_d   = ARB_IDLE;
          gnt_d     = '0;
          hold_d    = '0;
          ptr_d     = gnt_idx + IDX_W'(1);
          // Limit is reported even when done arrives on the same cycle.
          timeout_d = hold_limit;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx;
  assign bus.gnt_valid = gnt_valid;
  assign bus.timeout   = timeout_q;

endmodule : rr_arbiter_4
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Directed self-checking bench for rr_arbiter_4 (MAX_HOLD = 16).
//               Inputs change 1 time unit after each rising edge; outputs are
//               sampled at the same point, i.e. they show the state loaded at
//               the edge just passed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;
  import arb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] g, input logic [1:0] i,
                         input logic v, input logic t);
    chk({tag, ".gnt"},       32'(bus.gnt),       32'(g));
    chk({tag, ".gnt_idx"},   32'(bus.gnt_idx),   32'(i));
    chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(v));
    chk({tag, ".timeout"},   32'(bus.timeout),   32'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    rst_n    = 1'b0;

    // Reset and idle
    step();
    step();
    chk_bus("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_bus("idle", 4'b0000, 2'b00, 1'b0, 1'b0);
    end

    // All request: grants rotate 0,1,2,3,0 with a bubble after each
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] e;
      logic [3:0] oh;
      e  = 2'(k % 4);
      oh = 4'b0001 << e;
      step();
      chk_bus("rot_grant", oh, e, 1'b1, 1'b0);
      step();
      chk_bus("rot_hold", oh, e, 1'b1, 1'b0);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk_bus("rot_bubble", 4'b0000, 2'b00, 1'b0, 1'b0);
    end
    bus.req = 4'b0000;                        // ptr = 1

    // Hold limit: master 2 alone, no done
    bus.req = 4'b0100;
    step();
    chk_bus("lim_grant", 4'b0100, 2'b10, 1'b1, 1'b0);
    cnt = 0;
    while (bus.gnt == 4'b0100 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("lim_len", 32'(cnt), 32'd16);
    chk_bus("lim_timeout", 4'b0000, 2'b00, 1'b0, 1'b1);
    step();
    chk_bus("lim_regrant", 4'b0100, 2'b10, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    chk_bus("lim_release", 4'b0000, 2'b00, 1'b0, 1'b0);   // ptr = 3

    // Owner drops request while another master waits
    bus.req = 4'b0010;
    step();
    chk_bus("drop_grant", 4'b0010, 2'b01, 1'b1, 1'b0);
    bus.req = 4'b1010;
    step();
    chk_bus("drop_keep", 4'b0010, 2'b01, 1'b1, 1'b0);
    bus.req = 4'b1000;
    step();
    chk_bus("drop_bubble", 4'b0000, 2'b00, 1'b0, 1'b0);
    step();
    chk_bus("drop_next", 4'b1000, 2'b11, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    chk_bus("drop_release", 4'b0000, 2'b00, 1'b0, 1'b0);  // ptr = 0

    // done coincides with the hold limit
    bus.req = 4'b0001;
    step();
    chk_bus("coin_grant", 4'b0001, 2'b00, 1'b1, 1'b0);
    for (int c = 0; c < 15; c++) step();
    chk_bus("coin_last", 4'b0001, 2'b00, 1'b1, 1'b0);
    bus.done = 1'b1;
    bus.req  = 4'b0011;
    step();
    bus.done = 1'b0;
    chk_bus("coin_timeout", 4'b0000, 2'b00, 1'b0, 1'b1);
    step();
    chk_bus("coin_next", 4'b0010, 2'b01, 1'b1, 1'b0);     // ptr was 1

    // Asynchronous reset during master 3's grant
    bus.req = 4'b1000;
    step();
    chk_bus("ar_bubble", 4'b0000, 2'b00, 1'b0, 1'b0);
    step();
    chk_bus("ar_grant", 4'b1000, 2'b11, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_bus("ar_async", 4'b0000, 2'b00, 1'b0, 1'b0);
    bus.req = 4'b1001;
    step();
    step();
    chk_bus("ar_held", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_bus("ar_after", 4'b0001, 2'b00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rr_arbiter_4
`default_nettype wire
